// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a single full-subtractor cell feeding a result shift register.
// Handshake: start is accepted in IDLE or DONE; busy while shifting; done pulses
// for one cycle when d/bout are updated. d/bout hold until the next completion.
module serial_sub #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bout
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    sr_q, sr_d;
  logic            br_q, br_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    d_q, d_d;
  logic            bout_q, bout_d;

  // Full-subtractor cell on the current LSBs.
  logic         diff_bit;
  logic         br_next;
  logic [W-1:0] sr_next;

  assign diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sr_next  = {diff_bit, sr_q[W-1:1]};

  // Next-state logic: load, shift, complete.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        sa_d  = {1'b0, sa_q[W-1:1]};
        sb_d  = {1'b0, sb_q[W-1:1]};
        sr_d  = sr_next;
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Last bit: publish the result including this edge's bit.
          d_d     = sr_next;
          bout_d  = br_next;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    d    = d_q;
    bout = bout_q;
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboarded bench for serial_sub: directed handshake/reset cases, a W=8
// sweep instance, and a randomized regression against an arithmetic model.
module tb_serial_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] d;

  logic         start8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0;
  logic         bin8 = 1'b0;
  logic         busy8, done8, bout8;
  logic [7:0]   d8;

  serial_sub #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout)
  );

  serial_sub #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .bout(bout8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int bin;
    int load;
  } op_t;

  op_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  pulses = 0;
  int  pushed = 0;

  // Monitor: every done pulse is matched against the oldest outstanding op.
  op_t         m_op;
  int          m_diff;
  logic [W-1:0] m_expd;
  logic         m_expb;
  always @(negedge clk) begin
    if (rst_n && done) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got d=%0d bout=%0d, required no pulse", d, bout);
      end else begin
        m_op   = sb_q.pop_front();
        m_diff = m_op.a - m_op.b - m_op.bin;
        m_expd = W'(m_diff & ((1 << W) - 1));
        m_expb = (m_diff < 0);
        checks++;
        if (d !== m_expd || bout !== m_expb) begin
          failures++;
          $display("FAIL result a=%0d b=%0d bin=%0d: got d=%0d bout=%0d, required d=%0d bout=%0d",
                   m_op.a, m_op.b, m_op.bin, d, bout, m_expd, m_expb);
        end
        checks++;
        if (int'(d) - (1 << W) * int'(bout) != m_diff) begin
          failures++;
          $display("FAIL identity a=%0d b=%0d bin=%0d: got %0d, required %0d",
                   m_op.a, m_op.b, m_op.bin, int'(d) - (1 << W) * int'(bout), m_diff);
        end
        checks++;
        if (cyc != m_op.load + W) begin
          failures++;
          $display("FAIL latency: got done at edge %0d, required edge %0d", cyc, m_op.load + W);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Waits for ready (busy low), then presents start for one cycle.
  task automatic issue(input int av, input int bv, input int binv, input bit push);
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_ready_timeout", int'(busy), 0);
    a = W'(av);
    b = W'(bv);
    bin = binv[0];
    start = 1'b1;
    if (push) begin
      sb_q.push_back('{av, bv, binv, cyc + 1});
      pushed++;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    int n;
    int ld;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_d", int'(d), 0);
    check("reset_bout", int'(bout), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtract with busy duration
    issue(5, 3, 0, 1);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("busy_cycles", n, W);
    drain();

    // Negative wrap cases
    issue(3, 5, 0, 1);
    issue(0, 0, 1, 1);
    issue(15, 15, 1, 1);
    issue(0, 15, 1, 1);
    drain();

    // start while busy is ignored, then back-to-back load in the done cycle
    issue(9, 4, 0, 1);
    @(posedge clk); #1;
    a = 4'd1;
    b = W'($urandom_range(0, 15));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_done_timeout", int'(done), 1);
    issue(8, 8, 0, 1);
    n = 0;
    while (busy && n < 20) begin
      check("d_held", int'(d), 5);
      @(posedge clk); #1;
      n++;
    end
    drain();

    // Reset mid-operation aborts with no done pulse
    issue(12, 1, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_d", int'(d), 0);
    check("midrst_bout", int'(bout), 0);
    repeat (W + 2) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(7, 2, 1, 1);
    drain();

    // W=8 sweep instance
    a8 = 8'h00;
    b8 = 8'h01;
    bin8 = 1'b0;
    start8 = 1'b1;
    ld = cyc + 1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_done_edge", cyc, ld + 8);
    check("w8_d", int'(d8), 255);
    check("w8_bout", int'(bout8), 1);

    // Random regression
    for (int i = 0; i < 180; i++) begin
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), 1);
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("done_pulse_count", pulses, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
